// File: rtl/ram_dma_master_pkg.sv
// ram_dma_master_pkg: state encoding and direction constants shared by the DMA master
package ram_dma_master_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;
endpackage

// File: rtl/ram_dma_master_if.sv
// ram_dma_master_if: command, write/read streams, RAM port and status of the DMA master
interface ram_dma_master_if #(parameter int N = 8, parameter int M = 8);
  logic cmd_valid, cmd_ready, cmd_we;
  logic [M-1:0] cmd_addr, cmd_len;
  logic [N-1:0] wr_data;
  logic wr_valid, wr_ready;
  logic [N-1:0] rd_data;
  logic rd_valid, rd_ready;
  logic [M-1:0] ram_addr;
  logic [N-1:0] ram_din, ram_dout;
  logic ram_we;
  logic busy, done;
  modport master(
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ram_dout,
    output cmd_ready, wr_ready, rd_data, rd_valid, ram_addr, ram_din, ram_we, busy, done
  );
  modport slave(
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ram_dout,
    input  cmd_ready, wr_ready, rd_data, rd_valid, ram_addr, ram_din, ram_we, busy, done
  );
endinterface

// File: rtl/ram_dma_addr_gen.sv
// ram_dma_addr_gen: burst address pointer and remaining-beat counter
module ram_dma_addr_gen #(parameter int M = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [M-1:0] base,
  input  logic [M-1:0] len,
  output logic [M-1:0] ptr,
  output logic         last,
  output logic         empty
);
  logic [M:0] remaining;
  // load base/len+1 on command accept, advance (wrapping) on every moved beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= base;
      remaining <= {1'b0, len} + 1'b1;
    end else if (step) begin
      ptr       <= ptr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  assign last  = remaining == (M+1)'(1);
  assign empty = remaining == '0;
endmodule

// File: rtl/ram_dma_master.sv
// ram_dma_master: burst initiator on a single-port RAM; RAM_DMA_ABORT_EN adds abort/aborted
module ram_dma_master
  import ram_dma_master_pkg::*;
#(parameter int N = 8, parameter int M = 8) (
  input  logic clk,
  input  logic rst_n,
`ifdef RAM_DMA_ABORT_EN
  input  logic abort,
  output logic aborted,
`endif
  ram_dma_master_if.master bus
);
  state_t state;
  logic [M-1:0] ptr;
  logic [N-1:0] rd_data_q;
  logic rd_valid_q, last, empty, load, step, rd_load, rd_take, abort_hit;
`ifdef RAM_DMA_ABORT_EN
  assign abort_hit = abort && (state == S_WRITE || state == S_READ);
`else
  assign abort_hit = 1'b0;
`endif
  assign load    = state == S_IDLE && bus.cmd_valid;
  assign rd_take = rd_valid_q && bus.rd_ready;
  assign rd_load = state == S_READ && !empty && (!rd_valid_q || bus.rd_ready) && !abort_hit;
  assign step    = bus.ram_we || rd_load;
  ram_dma_addr_gen #(.M(M)) u_addr (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step),
    .base(bus.cmd_addr), .len(bus.cmd_len), .ptr(ptr), .last(last), .empty(empty)
  );
  // burst sequencing plus the registered read slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (abort_hit) begin
      state      <= S_DONE;
      rd_valid_q <= 1'b0;
    end else
      case (state)
        S_IDLE:  if (bus.cmd_valid) state <= bus.cmd_we == DIR_WR ? S_WRITE : S_READ;
        S_WRITE: if (bus.wr_valid && last) state <= S_DONE;
        S_READ:
          if (rd_load) begin
            rd_data_q  <= bus.ram_dout;
            rd_valid_q <= 1'b1;
          end else if (rd_take) begin
            rd_valid_q <= 1'b0;
            state      <= S_DONE;
          end
        default: state <= S_IDLE;
      endcase
`ifdef RAM_DMA_ABORT_EN
  // flag an aborted burst until the next command is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) aborted <= 1'b0;
    else if (load) aborted <= 1'b0;
    else if (abort_hit) aborted <= 1'b1;
`endif
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.busy      = state != S_IDLE;
  assign bus.done      = state == S_DONE;
  assign bus.wr_ready  = state == S_WRITE && !abort_hit;
  assign bus.ram_we    = bus.wr_ready && bus.wr_valid;
  assign bus.ram_addr  = ptr;
  assign bus.ram_din   = bus.wr_data;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
endmodule
